// File: rtl/bitonic_pkg.sv
// bitonic_pkg -- shared types and helpers for the bitonic_seq sorter.
//   state_t     : LOAD / SORT / DRAIN phases of the sequential sorter
//   sort_cycles : number of compare-swap cycles needed to sort n elements
package bitonic_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One compare-swap per cycle: (n/2) pairs per step, log2n*(log2n+1)/2 steps.
    function automatic int sort_cycles(input int n);
        int lg;
        lg = $clog2(n);
        return (n / 2) * lg * (lg + 1) / 2;
    endfunction

endpackage

// File: rtl/bitonic_seq_if.sv
// bitonic_seq_if -- handshake bundle between a producer/consumer and bitonic_seq.
//   clr                         : synchronous abort of the current batch
//   in_valid/in_ready/in_data   : element input stream
//   out_valid/out_ready/out_data/out_last : sorted element output stream
//   busy                        : sorter is in its compare-swap phase
// master = environment side, slave = sorter side.
interface bitonic_seq_if #(
    parameter int W = 8
);
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/bitonic_seq_bnode.sv
// bnode -- single compare-swap node.
//   a, b : operands (a belongs to the lower index, b to the upper index)
//   asc  : 1 = smaller value to lo, 0 = larger value to lo
//   lo, hi : results for the lower / upper index
// Equal operands never swap, so ties keep their order.
module bnode #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         asc,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);
    logic swap;

    always_comb begin
        swap = asc ? (a > b) : (a < b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end
endmodule

// File: rtl/bitonic_seq.sv
// bitonic_seq -- sequential bitonic sorter, one shared compare-swap per cycle.
// Loads N elements, sorts them in place in an N x W register buffer, then
// drains them in order.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bitonic_seq_if.slave (clr, in_* stream, out_* stream, busy)
// Build option: define BITONIC_SEQ_DESC_EN to drain largest-first instead of
// smallest-first; latency is identical either way.
module bitonic_seq
    import bitonic_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    bitonic_seq_if.slave bus
);
    localparam int LOGN     = $clog2(N);
    localparam int KW       = $clog2(LOGN + 1);
    localparam int PW       = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int SORT_CYC = sort_cycles(N);
    localparam int CW       = $clog2(SORT_CYC + 1);

`ifdef BITONIC_SEQ_DESC_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    state_t               state, state_nx;
    logic [LOGN-1:0]      wr_idx, rd_idx;
    logic [KW-1:0]        stage;     // log2(k) - 1
    logic [KW-1:0]        jj;        // log2(j)
    logic [PW-1:0]        p;         // pair number within a step
    logic [CW-1:0]        sort_cnt;
    logic [N-1:0][W-1:0]  buf_q;

    logic [LOGN-1:0]      p_ext, i_idx, l_idx;
    logic [LOGN:0]        i_wide;
    logic [KW-1:0]        kbit;
    logic                 asc;
    logic [W-1:0]         lo, hi;
    logic                 sort_last, in_fire, out_fire;

    // Pair index: insert a zero at bit position log2(j) of p.
    always_comb begin
        p_ext  = LOGN'(p);
        i_idx  = ((p_ext >> jj) << (jj + 1'b1)) | (p_ext & ((LOGN'(1) << jj) - 1'b1));
        l_idx  = i_idx | (LOGN'(1) << jj);
        // Extra top bit so the final stage (k == N) tests a zero bit -> all ascending.
        i_wide = {1'b0, i_idx};
        kbit   = stage + 1'b1;
        asc    = (i_wide[kbit] == 1'b0) ^ DESC;
    end

    bnode #(.W(W)) u_node (
        .a   (buf_q[i_idx]),
        .b   (buf_q[l_idx]),
        .asc (asc),
        .lo  (lo),
        .hi  (hi)
    );

    assign sort_last = (sort_cnt == CW'(SORT_CYC - 1));
    assign in_fire   = (state == LOAD)  && bus.in_valid  && !bus.clr;
    assign out_fire  = (state == DRAIN) && bus.out_ready && !bus.clr;

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state == SORT);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = buf_q[rd_idx];
    assign bus.out_last  = (state == DRAIN) && (rd_idx == LOGN'(N - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (in_fire && wr_idx == LOGN'(N - 1)) state_nx = SORT;
            SORT:    if (sort_last)                         state_nx = DRAIN;
            DRAIN:   if (out_fire && rd_idx == LOGN'(N - 1)) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
        if (bus.clr) state_nx = LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    // Indices wrap to zero naturally at the end of each phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            stage    <= '0;
            jj       <= '0;
            p        <= '0;
            sort_cnt <= '0;
        end else if (bus.clr) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            stage    <= '0;
            jj       <= '0;
            p        <= '0;
            sort_cnt <= '0;
        end else begin
            if (in_fire)  wr_idx <= wr_idx + 1'b1;
            if (out_fire) rd_idx <= rd_idx + 1'b1;
            if (state == SORT) begin
                sort_cnt <= sort_last ? '0 : sort_cnt + 1'b1;
                if (p == PW'(N / 2 - 1)) begin
                    p <= '0;
                    if (jj == '0) begin
                        if (sort_last) begin
                            stage <= '0;
                            jj    <= '0;
                        end else begin
                            stage <= stage + 1'b1;
                            jj    <= stage + 1'b1;
                        end
                    end else begin
                        jj <= jj - 1'b1;
                    end
                end else begin
                    p <= p + 1'b1;
                end
            end
        end
    end

    // Data buffer carries no reset; a fresh batch always overwrites it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[wr_idx] <= bus.in_data;
        end else if (state == SORT && !bus.clr) begin
            buf_q[i_idx] <= lo;
            buf_q[l_idx] <= hi;
        end
    end
endmodule
